// File: rtl/gigatron_input_pkg.sv
// Shared types and constants for the Gigatron keyboard/joystick input arbiter.
package gigatron_input_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        KEY_HOLD = 2'd1,
        KEY_GAP  = 2'd2
    } state_t;

    // Value shifted out when nothing is pressed (pad lines are active-low).
    localparam logic [7:0] IDLE_WORD = 8'hFF;

    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_A      = 4;
    localparam int JOY_B      = 5;
    localparam int JOY_SELECT = 6;
    localparam int JOY_START  = 7;

endpackage

// File: rtl/gigatron_key_fifo.sv
// Keyboard queue: FIFO_DEPTH-entry circular FIFO when GIGATRON_KBD_FIFO_EN is
// defined, otherwise a single holding register. Push and pop may coincide.
module gigatron_key_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_app,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

`ifdef GIGATRON_KBD_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_app) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk_app or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
`else
    logic       occupied;
    logic [7:0] hold;

    // A push alongside a pop replaces the departing code, so occupancy stays set.
    always_ff @(posedge clk_app or negedge reset_n) begin
        if (!reset_n) begin
            occupied <= 1'b0;
            hold     <= '0;
        end else if (push) begin
            occupied <= 1'b1;
            hold     <= din;
        end else if (pop) begin
            occupied <= 1'b0;
        end
    end

    assign dout  = hold;
    assign full  = occupied;
    assign empty = !occupied;
`endif

endmodule

// File: rtl/gigatron_input_arbiter.sv
// Famicom-style serial pad emulator merging a joystick and queued ASCII keys.
// Define GIGATRON_KBD_FIFO_EN for a multi-entry key FIFO instead of one register.
module gigatron_input_arbiter
    import gigatron_input_pkg::*;
#(
    parameter int HOLD_FRAMES = 3,
    parameter int GAP_FRAMES  = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk_app,
    input  logic       reset_n,
    input  logic [7:0] joystick,
    input  logic       key_valid,
    input  logic [7:0] key_ascii,
    input  logic       famicom_latch,
    input  logic       famicom_pulse,
    output logic       famicom_data,
    output logic       key_dropped,
    output logic       busy,
    output logic [1:0] fsm_state
);

    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam int GW = (GAP_FRAMES > 0) ? $clog2(GAP_FRAMES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_FRAMES > 0) ? GAP_FRAMES - 1 : 0);

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [7:0]    held_code, held_nxt;
    logic [7:0]    word, word_nxt;
    logic          latch_q, latch_d, pulse_q, pulse_d;
    logic          frame_tick, pulse_fall;
    logic          pop, push, drop, key_in, start_key;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;

    assign frame_tick = latch_q && !latch_d;
    assign pulse_fall = !pulse_q && pulse_d;

    assign key_in = key_valid && (key_ascii != 8'h00);
    assign push   = key_in && (!fifo_full || pop);
    assign drop   = key_in && fifo_full && !pop;

    gigatron_key_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_app (clk_app),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (key_ascii),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Counters hold the number of frames still to come after the current one.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        gap_nxt   = gap_cnt;
        held_nxt  = held_code;
        word_nxt  = word;
        pop       = 1'b0;
        start_key = 1'b0;
        if (frame_tick) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) start_key = 1'b1;
                    else             word_nxt  = ~joystick;
                end
                KEY_HOLD: begin
                    if (hold_cnt == '0) begin
                        state_nxt = KEY_GAP;
                        gap_nxt   = GAP_LAST;
                        word_nxt  = IDLE_WORD;
                    end else begin
                        hold_nxt = hold_cnt - 1'b1;
                        word_nxt = held_code;
                    end
                end
                KEY_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_nxt  = gap_cnt - 1'b1;
                        word_nxt = IDLE_WORD;
                    end else if (!fifo_empty) begin
                        start_key = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        word_nxt  = ~joystick;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    word_nxt  = IDLE_WORD;
                end
            endcase
            if (start_key) begin
                pop       = 1'b1;
                state_nxt = KEY_HOLD;
                hold_nxt  = HOLD_LAST;
                held_nxt  = fifo_dout;
                word_nxt  = fifo_dout;
            end
        end else if (pulse_fall && !latch_q) begin
            word_nxt = {1'b1, word[7:1]};
        end
    end

    always_ff @(posedge clk_app or negedge reset_n) begin
        if (!reset_n) begin
            latch_q     <= 1'b0;
            latch_d     <= 1'b0;
            pulse_q     <= 1'b0;
            pulse_d     <= 1'b0;
            state       <= IDLE;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            held_code   <= IDLE_WORD;
            word        <= IDLE_WORD;
            key_dropped <= 1'b0;
        end else begin
            latch_q     <= famicom_latch;
            latch_d     <= latch_q;
            pulse_q     <= famicom_pulse;
            pulse_d     <= pulse_q;
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            gap_cnt     <= gap_nxt;
            held_code   <= held_nxt;
            word        <= word_nxt;
            key_dropped <= drop;
        end
    end

    assign famicom_data = word[0];
    assign busy         = (state != IDLE) || !fifo_empty;
    assign fsm_state    = state;

endmodule

// File: tb/tb_gigatron_input_arbiter.sv
// Directed bench for gigatron_input_arbiter: each latch frame's expected word is
// queued when the frame is started and compared with the shifted-out bits.
module tb_gigatron_input_arbiter;
    import gigatron_input_pkg::*;

    logic       clk_app       = 1'b0;
    logic       reset_n       = 1'b0;
    logic [7:0] joystick      = 8'h00;
    logic       key_valid     = 1'b0;
    logic [7:0] key_ascii     = 8'h00;
    logic       famicom_latch = 1'b0;
    logic       famicom_pulse = 1'b0;
    logic       famicom_data;
    logic       key_dropped;
    logic       busy;
    logic [1:0] fsm_state;

    logic [7:0] exp_q[$];
    logic [7:0] mid_bits;
    int checks    = 0;
    int errors    = 0;
    int drop_seen = 0;
    int frame_no  = 0;

    gigatron_input_arbiter dut (
        .clk_app       (clk_app),
        .reset_n       (reset_n),
        .joystick      (joystick),
        .key_valid     (key_valid),
        .key_ascii     (key_ascii),
        .famicom_latch (famicom_latch),
        .famicom_pulse (famicom_pulse),
        .famicom_data  (famicom_data),
        .key_dropped   (key_dropped),
        .busy          (busy),
        .fsm_state     (fsm_state)
    );

    // Clock and drop monitor
    always #80 clk_app = ~clk_app;

    always @(negedge clk_app) if (key_dropped === 1'b1) drop_seen++;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_app);
        #1;
    endtask

    task automatic send_key(input logic [7:0] code);
        key_valid = 1'b1;
        key_ascii = code;
        cycles(1);
        key_valid = 1'b0;
        key_ascii = 8'h00;
    endtask

    task automatic shift_bit(output logic b);
        @(negedge clk_app);
        b = famicom_data;
        #1 famicom_pulse = 1'b1;
        cycles(2);
        famicom_pulse = 1'b0;
        cycles(2);
    endtask

    // One latch plus eight pulses; inject is pushed on the latch-tick cycle.
    task automatic run_frame(input logic [7:0] inject);
        logic [7:0] got;
        logic [7:0] expw;
        frame_no++;
        famicom_latch = 1'b1;
        cycles(1);
        if (inject != 8'h00) begin
            key_valid = 1'b1;
            key_ascii = inject;
        end
        cycles(1);
        key_valid = 1'b0;
        key_ascii = 8'h00;
        cycles(2);
        famicom_latch = 1'b0;
        cycles(2);
        for (int i = 0; i < 8; i++) shift_bit(got[i]);
        @(negedge clk_app);
        check($sformatf("frame%0d_fill", frame_no), {7'd0, famicom_data}, 8'h01);
        expw = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check($sformatf("frame%0d_word", frame_no), got, expw);
        @(posedge clk_app);
        #1;
    endtask

    task automatic expect_frame(input logic [7:0] expw, input logic [7:0] inject);
        exp_q.push_back(expw);
        run_frame(inject);
    endtask

    task automatic expect_key(input logic [7:0] code, input logic [7:0] joy_after);
        repeat (3) expect_frame(code, 8'h00);
        repeat (2) expect_frame(8'hFF, 8'h00);
        expect_frame(~joy_after, 8'h00);
    endtask

    initial begin
        // Reset state
        cycles(2);
        check("rst_data", {7'd0, famicom_data}, 8'h01);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_drop", {7'd0, key_dropped}, 8'h00);
        check("rst_state", {6'd0, fsm_state}, 8'(IDLE));
        reset_n = 1'b1;
        cycles(3);
        shift_bit(mid_bits[0]);
        shift_bit(mid_bits[1]);
        check("post_rst_idle_bits", {6'd0, mid_bits[1:0]}, 8'h03);

        // Joystick only: Right pressed
        joystick = 8'h01;
        expect_frame(8'hFE, 8'h00);
        check("joy_busy", {7'd0, busy}, 8'h00);

        // Single key; joystick changes while the key owns the line
        drop_seen = 0;
        send_key(8'h41);
        check("key41_busy", {7'd0, busy}, 8'h01);
        check("key41_state_idle", {6'd0, fsm_state}, 8'(IDLE));
        repeat (3) expect_frame(8'h41, 8'h00);
        check("key41_state_hold", {6'd0, fsm_state}, 8'(KEY_HOLD));
        joystick = 8'h55;
        repeat (2) expect_frame(8'hFF, 8'h00);
        check("key41_state_gap", {6'd0, fsm_state}, 8'(KEY_GAP));
        expect_frame(8'hAA, 8'h00);
        check("key41_busy_end", {7'd0, busy}, 8'h00);

        // Two keys back to back
        joystick = 8'h80;
`ifdef GIGATRON_KBD_FIFO_EN
        key_valid = 1'b1;
        key_ascii = 8'h61;
        cycles(1);
        key_ascii = 8'h62;
        cycles(1);
        key_valid = 1'b0;
        key_ascii = 8'h00;
        repeat (3) expect_frame(8'h61, 8'h00);
`else
        send_key(8'h61);
        expect_frame(8'h61, 8'h00);
        send_key(8'h62);
        repeat (2) expect_frame(8'h61, 8'h00);
`endif
        repeat (2) expect_frame(8'hFF, 8'h00);
        expect_key(8'h62, 8'h80);
        check("ab_no_drop", 8'(drop_seen), 8'h00);

        // Push coinciding with the pop tick
        joystick = 8'h0F;
        send_key(8'h51);
        expect_frame(8'h51, 8'h52);
        repeat (2) expect_frame(8'h51, 8'h00);
        repeat (2) expect_frame(8'hFF, 8'h00);
        expect_key(8'h52, 8'h0F);
        check("pushpop_no_drop", 8'(drop_seen), 8'h00);

        // NUL code is ignored
        send_key(8'h00);
        cycles(1);
        check("nul_busy", {7'd0, busy}, 8'h00);
        check("nul_no_drop", 8'(drop_seen), 8'h00);

        // Overflow
        joystick = 8'h02;
`ifdef GIGATRON_KBD_FIFO_EN
        for (int k = 0; k < 5; k++) begin
            key_valid = 1'b1;
            key_ascii = 8'(8'h31 + k);
            cycles(1);
        end
`else
        for (int k = 0; k < 2; k++) begin
            key_valid = 1'b1;
            key_ascii = 8'(8'h31 + k);
            cycles(1);
        end
`endif
        key_valid = 1'b0;
        key_ascii = 8'h00;
        check("ovf_drop_pulse", {7'd0, key_dropped}, 8'h01);
        cycles(1);
        check("ovf_drop_end", {7'd0, key_dropped}, 8'h00);
        check("ovf_drop_count", 8'(drop_seen), 8'h01);
`ifdef GIGATRON_KBD_FIFO_EN
        for (int k = 0; k < 3; k++) begin
            repeat (3) expect_frame(8'(8'h31 + k), 8'h00);
            repeat (2) expect_frame(8'hFF, 8'h00);
        end
        expect_key(8'h34, 8'h02);
`else
        expect_key(8'h31, 8'h02);
`endif
        check("ovf_busy_end", {7'd0, busy}, 8'h00);

        // Reset in the middle of a held key's shift
        send_key(8'h41);
        famicom_latch = 1'b1;
        cycles(4);
        famicom_latch = 1'b0;
        cycles(2);
        for (int i = 0; i < 3; i++) shift_bit(mid_bits[i]);
        check("mid_bits", {5'd0, mid_bits[2:0]}, 8'h01);
        check("mid_state", {6'd0, fsm_state}, 8'(KEY_HOLD));
        @(negedge clk_app);
        check("mid_data_before", {7'd0, famicom_data}, 8'h00);
        reset_n = 1'b0;
        #1;
        check("mid_rst_data", {7'd0, famicom_data}, 8'h01);
        check("mid_rst_busy", {7'd0, busy}, 8'h00);
        check("mid_rst_state", {6'd0, fsm_state}, 8'(IDLE));
        cycles(2);
        reset_n = 1'b1;
        cycles(3);
        check("mid_post_data", {7'd0, famicom_data}, 8'h01);
        joystick = 8'h24;
        expect_frame(8'hDB, 8'h00);
        check("mid_post_busy", {7'd0, busy}, 8'h00);

        check("sb_drained", 8'(exp_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
